lib_cmps_from_pow2: RTL
=======================

Name: lib_cmps_from_pow2

Overview:
- Serial recomposer: accepts a frame of one-hot vectors (one per beat) and ORs them back into a single WIDTH-bit vector. It is the inverse of the pow2 decomposition stage.
- Counts contributing bits and flags malformed frames: non-one-hot beats, duplicate bits and out-of-order bits.
- Sits downstream of per-bit processing lanes. It rebuilds the error/position vector before it is handed to the next stage over a valid/ready interface.

Parameters:
- WIDTH, 16, width of each one-hot beat and of the composed vector.
- LSB_MSB, 0, required bit order within a frame: 0 = ascending index (LSB first), 1 = descending index (MSB first).
- ORDER_CHK, 1, 1 = enable order checking; 0 = err_order_o is tied to 0.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- onehot_i, input, WIDTH, incoming beat; may be zero (bypassed slot).
- vld_i, input, 1, beat valid.
- last_i, input, 1, final beat of frame; qualified by vld_i.
- rdy_o, output, 1, block can accept a beat.
- vect_o, output, WIDTH, composed vector.
- cnt_o, output, $clog2(WIDTH+1), number of non-zero beats accumulated.
- err_onehot_o, output, 1, at least one beat had more than one bit set.
- err_dup_o, output, 1, at least one beat hit a bit already accumulated.
- err_order_o, output, 1, at least one beat violated LSB_MSB order.
- vld_o, output, 1, composed result valid.
- rdy_i, input, 1, downstream accepts the result.

Behaviour:
- Reset (async assert, sync deassert):
  - State = WAIT.
  - All registered outputs = 0: rdy_o, vld_o, vect_o, cnt_o, all err_*.
  - The internal accumulator, count and error registers are cleared.
  - Reset mid-frame discards the partial frame; no output is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine:
  - WAIT → ACCUM unconditionally on the first clk after reset deasserts. rdy_o rises in that same edge.
  - ACCUM:
    - rdy_o = 1, vld_o = 0.
    - A beat is accepted when vld_i & rdy_o.
    - Accepted with last_i = 0: the beat is merged, state stays ACCUM.
    - Accepted with last_i = 1: the beat is merged and the result registered. State → OUT, vld_o = 1 and rdy_o = 0, all on the same edge.
  - OUT:
    - vect_o, cnt_o and err_* are held stable while vld_o = 1 and rdy_i = 0.
    - On rdy_i = 1: vld_o = 0, rdy_o = 1, accumulator/count/errors are cleared, state → ACCUM.
    - vect_o/cnt_o/err_* keep their last value after the handshake; they are meaningful only when vld_o = 1.
- Merge rules per accepted beat b, with accumulator A:
  - A_next = A | b.
  - b == 0: no count change, no error; order state is unchanged.
  - popcount(b) == 1: cnt increments by 1, saturating at WIDTH.
  - popcount(b) > 1: set err_onehot. Bits are still ORed; cnt increments by 1.
  - (A & b) != 0: set err_dup.
  - Order check, when ORDER_CHK = 1, b != 0 and A != 0:
    - LSB_MSB = 0: lowest set bit of b must be above highest set bit of A, else set err_order.
    - LSB_MSB = 1: highest set bit of b must be below lowest set bit of A, else set err_order.
  - Error flags are sticky for the frame; several may be set simultaneously.
- Latency and throughput:
  - vld_o asserts 1 cycle after the last beat is accepted.
  - Minimum frame cost is N beats + 1 OUT cycle; rdy_o is low during OUT.
- A single-beat frame (vld_i & last_i on the first beat) is legal.
- An all-zero frame is legal and yields vect_o = 0, cnt_o = 0, no errors.
- vld_i while rdy_o = 0 is ignored; upstream must hold the beat until accepted.
- last_i without vld_i is ignored.

Test Plan (WIDTH=8, LSB_MSB=0, ORDER_CHK=1):
- Beats 0x01, 0x04, 0x80(last), rdy_i=1 → vld_o one cycle after 0x80. Result vect_o=0x85, cnt_o=3, no errors; rdy_o back to 1 the cycle after the handshake.
- Beats 0x02, 0x00, 0x10(last) → vect_o=0x12, cnt_o=2, no errors (zero beat treated as bypass).
- Beats 0x08, 0x08(last) → vect_o=0x08, cnt_o=2, err_dup_o=1, err_order_o=1.
- Beat 0x21 alone with last → vect_o=0x21, cnt_o=1, err_onehot_o=1. Next frame 0x40(last) → vect_o=0x40 with all errors cleared.
- Backpressure: frame 0x01(last) with rdy_i=0 for 5 cycles → vld_o and vect_o=0x01 held, rdy_o=0. A vld_i beat presented during OUT is not consumed and is accepted after rdy_i rises.
- rst asserted after beat 0x04 mid-frame → all outputs 0 immediately. rdy_o=1 one clk after release. Frame 0x02(last) → vect_o=0x02, cnt_o=1, showing no residue from the aborted frame.

Source files
------------

// File: rtl/lib_cmps_from_pow2.sv
// lib_cmps_from_pow2
//   Serial recomposer. It takes a frame of one-hot beats, one beat per accepted
//   transfer, and ORs them back into a single WIDTH-bit vector. It also counts
//   the non-zero beats and flags frames that are malformed: a beat with several
//   bits set, a bit that was already present, or a bit that arrives out of order.
//
// Ports
//   clk, rst       : clock and asynchronous active-high reset
//   onehot_i       : incoming beat; a zero beat is a bypassed slot
//   vld_i, last_i  : beat valid and end of frame (last_i counts only with vld_i)
//   rdy_o          : the block can accept a beat
//   vect_o, cnt_o  : composed vector and number of non-zero beats
//   err_*_o        : sticky per-frame error flags
//   vld_o, rdy_i   : result valid/ready handshake towards the next stage
module lib_cmps_from_pow2 #(
  parameter int WIDTH     = 16,
  parameter int LSB_MSB   = 0,
  parameter int ORDER_CHK = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               onehot_i,
  input  logic                           vld_i,
  input  logic                           last_i,
  output logic                           rdy_o,
  output logic [WIDTH-1:0]               vect_o,
  output logic [$clog2(WIDTH+1)-1:0]     cnt_o,
  output logic                           err_onehot_o,
  output logic                           err_dup_o,
  output logic                           err_order_o,
  output logic                           vld_o,
  input  logic                           rdy_i
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VEC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IW-1:0] lo_idx(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = {IW{1'b0}};
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
      else      r = r;
    end
    return r;
  endfunction

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [IW-1:0] hi_idx(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IW'(i);
      else      r = r;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  // Frame accumulator, kept apart from the output registers so the result
  // stays visible after the handshake while the next frame builds up.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
  logic             acc_eoh_q, acc_eoh_d;
  logic             acc_edup_q, acc_edup_d;
  logic             acc_eord_q, acc_eord_d;
  logic [WIDTH-1:0] vect_q, vect_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eoh_q, eoh_d;
  logic             edup_q, edup_d;
  logic             eord_q, eord_d;

  logic             beat_take_s;
  logic             beat_nz_s;
  logic             beat_multi_s;
  logic             beat_dup_s;
  logic             beat_ord_bad_s;
  logic [WIDTH-1:0] m_acc_s;
  logic [CW-1:0]    m_cnt_s;

  // Merge of the current beat into the accumulator.
  always_comb begin
    beat_take_s  = vld_i & rdy_q & (state_q == S_ACCUM);
    beat_nz_s    = |onehot_i;
    // b & (b-1) clears the lowest set bit; anything left means >1 bit set.
    beat_multi_s = |(onehot_i & (onehot_i - VEC_ONE));
    beat_dup_s   = |(acc_q & onehot_i);
    beat_ord_bad_s = 1'b0;
    if ((ORDER_CHK != 0) && beat_nz_s && (|acc_q)) begin
      if (LSB_MSB == 0) beat_ord_bad_s = (lo_idx(onehot_i) <= hi_idx(acc_q));
      else              beat_ord_bad_s = (hi_idx(onehot_i) >= lo_idx(acc_q));
    end else begin
      beat_ord_bad_s = 1'b0;
    end
    m_acc_s = acc_q | onehot_i;
    if (beat_nz_s && (acc_cnt_q != CNT_MAX)) m_cnt_s = acc_cnt_q + CNT_ONE;
    else                                     m_cnt_s = acc_cnt_q;
  end

  // Next-state and next-output logic of the frame FSM.
  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy_q;
    vld_d      = vld_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    acc_eoh_d  = acc_eoh_q;
    acc_edup_d = acc_edup_q;
    acc_eord_d = acc_eord_q;
    vect_d     = vect_q;
    cnt_d      = cnt_q;
    eoh_d      = eoh_q;
    edup_d     = edup_q;
    eord_d     = eord_q;
    case (state_q)
      S_WAIT: begin
        state_d = S_ACCUM;
        rdy_d   = 1'b1;
        vld_d   = 1'b0;
      end
      S_ACCUM: begin
        if (beat_take_s && last_i) begin
          vect_d     = m_acc_s;
          cnt_d      = m_cnt_s;
          eoh_d      = acc_eoh_q  | beat_multi_s;
          edup_d     = acc_edup_q | beat_dup_s;
          eord_d     = acc_eord_q | beat_ord_bad_s;
          acc_d      = {WIDTH{1'b0}};
          acc_cnt_d  = {CW{1'b0}};
          acc_eoh_d  = 1'b0;
          acc_edup_d = 1'b0;
          acc_eord_d = 1'b0;
          state_d    = S_OUT;
          rdy_d      = 1'b0;
          vld_d      = 1'b1;
        end else if (beat_take_s) begin
          acc_d      = m_acc_s;
          acc_cnt_d  = m_cnt_s;
          acc_eoh_d  = acc_eoh_q  | beat_multi_s;
          acc_edup_d = acc_edup_q | beat_dup_s;
          acc_eord_d = acc_eord_q | beat_ord_bad_s;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_OUT: begin
        if (rdy_i) begin
          state_d    = S_ACCUM;
          rdy_d      = 1'b1;
          vld_d      = 1'b0;
          acc_d      = {WIDTH{1'b0}};
          acc_cnt_d  = {CW{1'b0}};
          acc_eoh_d  = 1'b0;
          acc_edup_d = 1'b0;
          acc_eord_d = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_WAIT;
        rdy_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      acc_q      <= {WIDTH{1'b0}};
      acc_cnt_q  <= {CW{1'b0}};
      acc_eoh_q  <= 1'b0;
      acc_edup_q <= 1'b0;
      acc_eord_q <= 1'b0;
      vect_q     <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      eoh_q      <= 1'b0;
      edup_q     <= 1'b0;
      eord_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      vld_q      <= vld_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_eoh_q  <= acc_eoh_d;
      acc_edup_q <= acc_edup_d;
      acc_eord_q <= acc_eord_d;
      vect_q     <= vect_d;
      cnt_q      <= cnt_d;
      eoh_q      <= eoh_d;
      edup_q     <= edup_d;
      eord_q     <= eord_d;
    end
  end

  assign rdy_o        = rdy_q;
  assign vld_o        = vld_q;
  assign vect_o       = vect_q;
  assign cnt_o        = cnt_q;
  assign err_onehot_o = eoh_q;
  assign err_dup_o    = edup_q;
  assign err_order_o  = eord_q;

endmodule
